// File: rtl/car_detect_counter_if.sv
// +--------------------------------------------------------------------------+
// | car_detect_counter_if                                                    |
// | Lane-counter bus: tick/detector/clear in, count/car_pulse/overflow out.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface car_detect_counter_if;
  logic        tick_1ms;
  logic        detector;
  logic        clear;
  logic [13:0] count;
  logic        car_pulse;
  logic        overflow;

  modport master (
    output tick_1ms, detector, clear,
    input  count, car_pulse, overflow
  );

  modport slave (
    input  tick_1ms, detector, clear,
    output count, car_pulse, overflow
  );
endinterface

`default_nettype wire

// File: rtl/car_detect_counter.sv
// +--------------------------------------------------------------------------+
// | car_detect_counter                                                       |
// | Synchronises and debounces one loop detector on the 1 ms tick and counts |
// | each accepted arrival. Define CAR_COUNT_SATURATE_EN for a saturating     |
// | count with sticky overflow; otherwise the count wraps to 0.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module car_detect_counter #(
  parameter int DEB_MS    = 20,
  parameter int MAX_COUNT = 9999
) (
  input  logic                 clock,
  input  logic                 reset,
  car_detect_counter_if.slave  bus
);

  localparam int                 c_deb_w    = $clog2(DEB_MS);
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_MS - 1);
  localparam logic [c_deb_w-1:0] c_deb_one  = c_deb_w'(1);
  localparam logic [13:0]        c_max      = 14'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CONFIRM_HI = 2'd1,
    PRESENT    = 2'd2,
    CONFIRM_LO = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_deb_w-1:0] r_deb_cnt;
  logic [c_deb_w-1:0] w_deb_nxt;
  logic               w_accept;
  logic               r_sync1;
  logic               r_det_s;
  logic [13:0]        r_count;
  logic               r_car_pulse;
  logic               r_overflow;
  logic               w_at_max;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_det_s   <= 1'b0;
      r_state   <= IDLE;
      r_deb_cnt <= '0;
    end else begin
      r_sync1   <= bus.detector;
      r_det_s   <= r_sync1;
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_deb_nxt;
    end
  end

  // Debounce FSM only moves on tick clocks; an arrival is the CONFIRM_HI -> PRESENT step.
  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb_cnt;
    w_accept    = 1'b0;
    if (bus.tick_1ms) begin
      case (r_state)
        IDLE: begin
          if (r_det_s) begin
            w_state_nxt = CONFIRM_HI;
            w_deb_nxt   = c_deb_one;
          end
        end
        CONFIRM_HI: begin
          if (!r_det_s) begin
            w_state_nxt = IDLE;
            w_deb_nxt   = '0;
          end else if (r_deb_cnt == c_deb_last) begin
            w_state_nxt = PRESENT;
            w_deb_nxt   = '0;
            w_accept    = 1'b1;
          end else begin
            w_deb_nxt   = r_deb_cnt + c_deb_one;
          end
        end
        PRESENT: begin
          if (!r_det_s) begin
            w_state_nxt = CONFIRM_LO;
            w_deb_nxt   = c_deb_one;
          end
        end
        CONFIRM_LO: begin
          if (r_det_s) begin
            w_state_nxt = PRESENT;
            w_deb_nxt   = '0;
          end else if (r_deb_cnt == c_deb_last) begin
            w_state_nxt = IDLE;
            w_deb_nxt   = '0;
          end else begin
            w_deb_nxt   = r_deb_cnt + c_deb_one;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_deb_nxt   = '0;
        end
      endcase
    end
  end

  assign w_at_max = (r_count == c_max);

  // Clear beats a same-clock arrival for the count, but car_pulse still fires.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count     <= '0;
      r_car_pulse <= 1'b0;
    end else begin
      r_car_pulse <= w_accept;
      if (bus.clear) begin
        r_count <= '0;
      end else if (w_accept) begin
        if (!w_at_max) begin
          r_count <= r_count + 14'd1;
        end else begin
`ifdef CAR_COUNT_SATURATE_EN
          r_count <= c_max;
`else
          r_count <= '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else begin
`ifdef CAR_COUNT_SATURATE_EN
      if (bus.clear) begin
        r_overflow <= 1'b0;
      end else if (w_accept && w_at_max) begin
        r_overflow <= 1'b1;
      end
`else
      r_overflow <= w_accept && w_at_max;
`endif
    end
  end

  assign bus.count     = r_count;
  assign bus.car_pulse = r_car_pulse;
  assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_car_detect_counter.sv
// +--------------------------------------------------------------------------+
// | tb_car_detect_counter                                                    |
// | Directed self-checking bench for car_detect_counter (DEB_MS=4).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_car_detect_counter;

  localparam int c_deb = 4;
  localparam int c_max = 25;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_err;
  int   pulse_cnt;
  int   ov_pulse;
  int   ov_stray;
  int   tdiv;

  car_detect_counter_if bus ();

  car_detect_counter #(
    .DEB_MS    (c_deb),
    .MAX_COUNT (c_max)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.car_pulse === 1'b1) pulse_cnt++;
    if (bus.overflow === 1'b1 && bus.car_pulse === 1'b1) ov_pulse++;
    if (bus.overflow === 1'b1 && bus.car_pulse !== 1'b1) ov_stray++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic vehicle(input int hi, input int lo);
    bus.detector = 1'b1;
    repeat (hi) @(negedge clock);
    bus.detector = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic run_ticked(input int n);
    repeat (n) begin
      bus.tick_1ms = (tdiv == 49);
      tdiv = (tdiv == 49) ? 0 : tdiv + 1;
      @(negedge clock);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int p0;
    int ov0;
    n_chk = 0; n_err = 0; pulse_cnt = 0; ov_pulse = 0; ov_stray = 0; tdiv = 0;
    reset = 1'b1;
    bus.tick_1ms = 1'b1;
    bus.detector = 1'b1;
    bus.clear    = 1'b0;

    // 1: reset with detector high, then first arrival latency
    repeat (3) @(negedge clock);
    check_eq("rst_count", 32'(bus.count), 0);
    check_eq("rst_pulse", 32'(bus.car_pulse), 0);
    check_eq("rst_ovf", 32'(bus.overflow), 0);
    reset = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (bus.car_pulse === 1'b1 && lat == 0) lat = i;
    end
    check_eq("first_pulse_lat", 32'(lat), 6);
    check_eq("first_count", 32'(bus.count), 1);
    bus.detector = 1'b0;
    repeat (10) @(negedge clock);

    // 2: clear, then a 3-clock glitch
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    check_eq("clear_count", 32'(bus.count), 0);
    p0 = pulse_cnt;
    vehicle(3, 12);
    check_eq("glitch_pulses", 32'(pulse_cnt - p0), 0);
    check_eq("glitch_count", 32'(bus.count), 0);

    // 3: five clean vehicles, then one with a short dropout
    p0 = pulse_cnt;
    for (int v = 0; v < 5; v++) vehicle(10, 10);
    check_eq("five_pulses", 32'(pulse_cnt - p0), 5);
    check_eq("five_count", 32'(bus.count), 5);
    p0 = pulse_cnt;
    bus.detector = 1'b1;
    repeat (6) @(negedge clock);
    bus.detector = 1'b0;
    repeat (2) @(negedge clock);
    vehicle(6, 10);
    check_eq("gap_pulses", 32'(pulse_cnt - p0), 1);
    check_eq("gap_count", 32'(bus.count), 6);

    // 4: run up to MAX_COUNT, then one more arrival
    for (int v = 6; v < c_max; v++) vehicle(5, 5);
    repeat (5) @(negedge clock);
    check_eq("at_max_count", 32'(bus.count), 32'(c_max));
    check_eq("at_max_ovf", 32'(bus.overflow), 0);
    ov0 = ov_pulse;
    vehicle(5, 10);
`ifdef CAR_COUNT_SATURATE_EN
    check_eq("sat_count", 32'(bus.count), 32'(c_max));
    check_eq("sat_ovf", 32'(bus.overflow), 1);
    repeat (5) @(negedge clock);
    check_eq("sat_ovf_sticky", 32'(bus.overflow), 1);
`else
    check_eq("wrap_count", 32'(bus.count), 0);
    check_eq("wrap_ovf_pulses", 32'(ov_pulse - ov0), 1);
    check_eq("wrap_ovf_stray", 32'(ov_stray), 0);
    check_eq("wrap_ovf_low", 32'(bus.overflow), 0);
`endif
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    check_eq("ovf_clear_count", 32'(bus.count), 0);
    check_eq("ovf_clear_ovf", 32'(bus.overflow), 0);

    // 5: clear on the same clock as the arrival
    repeat (10) @(negedge clock);
    vehicle(5, 10);
    check_eq("pre_clr_count", 32'(bus.count), 1);
    bus.detector = 1'b1;
    repeat (5) @(negedge clock);
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    check_eq("clr_win_pulse", 32'(bus.car_pulse), 1);
    check_eq("clr_win_count", 32'(bus.count), 0);
    repeat (3) @(negedge clock);
    bus.detector = 1'b0;
    repeat (10) @(negedge clock);
    vehicle(10, 10);
    check_eq("after_clr_count", 32'(bus.count), 1);

    // 6: slow tick, one period every 50 clocks
    p0 = pulse_cnt;
    tdiv = 0;
    bus.detector = 1'b1;
    run_ticked(150);
    bus.detector = 1'b0;
    run_ticked(250);
    check_eq("slow150_count", 32'(bus.count), 1);
    check_eq("slow150_pulses", 32'(pulse_cnt - p0), 0);
    bus.detector = 1'b1;
    run_ticked(250);
    bus.detector = 1'b0;
    run_ticked(250);
    check_eq("slow250_count", 32'(bus.count), 2);
    check_eq("slow250_pulses", 32'(pulse_cnt - p0), 1);
    bus.tick_1ms = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
